// File: rtl/tremolo_pkg.sv
// Shared types, defaults and gain constants for the tremolo stage.
// The optional gain slewer is enabled with the TREMOLO_SMOOTH_EN macro.
package tremolo_pkg;

    typedef enum logic {
        SHAPE_SQUARE   = 1'b0,
        SHAPE_TRIANGLE = 1'b1
    } shape_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_PHASE_W = 12;
    localparam int DEF_GAIN_W  = 8;

    // Unity gain in GAIN_W fractional bits.
    function automatic int unsigned unity_gain(input int unsigned gain_w);
        return 32'd1 << gain_w;
    endfunction

    // Largest per-sample gain change allowed by the slewer.
    function automatic int unsigned slew_step(input int unsigned gain_w);
        return 32'd1 << (gain_w - 32'd3);
    endfunction

endpackage

// File: rtl/tremolo_lfo.sv
// LFO for the tremolo stage: phase accumulator advanced per accepted sample,
// mapped combinationally to a square or triangle value for the current phase.
module tremolo_lfo
    import tremolo_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int GAIN_W  = DEF_GAIN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               accept,
    input  logic [PHASE_W-1:0] rate,
    input  shape_e             shape,
    output logic [GAIN_W-1:0]  lfo
);

    logic [PHASE_W-1:0] phase;
    logic [GAIN_W:0]    tri_t;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!en) begin
            phase <= '0;
        end else if (accept) begin
            phase <= phase + rate;
        end
    end

    assign tri_t = phase[PHASE_W-1 -: GAIN_W+1];

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        lfo = '0;
        case (shape)
            SHAPE_SQUARE:   lfo = {GAIN_W{phase[PHASE_W-1]}};
            SHAPE_TRIANGLE: lfo = tri_t[GAIN_W] ? ~tri_t[GAIN_W-1:0] : tri_t[GAIN_W-1:0];
            default:        lfo = '0;
        endcase
    end

endmodule

// File: rtl/tremolo_mod.sv
// Tremolo amplitude modulator: LFO-driven fixed-point gain, two-stage pipeline.
// Define TREMOLO_SMOOTH_EN to insert a slew-limited gain register before the multiply.
module tremolo_mod
    import tremolo_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int GAIN_W  = DEF_GAIN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] audio_in,
    input  logic [PHASE_W-1:0]       rate,
    input  logic [GAIN_W-1:0]        depth,
    input  logic                     shape,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] audio_out
);

    localparam int PROD_W = DATA_W + GAIN_W + 2;
    localparam logic [GAIN_W:0] UNITY = (GAIN_W+1)'(unity_gain(GAIN_W));

    logic [GAIN_W-1:0]   lfo;
    logic [2*GAIN_W-1:0] depth_lfo;
    logic [GAIN_W:0]     gain_target;
    logic [GAIN_W:0]     gain_use;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_sample;
    logic [GAIN_W:0]          s1_gain;

    logic signed [PROD_W-1:0] prod_a;
    logic signed [PROD_W-1:0] prod_b;
    logic signed [PROD_W-1:0] prod;

    tremolo_lfo #(
        .PHASE_W (PHASE_W),
        .GAIN_W  (GAIN_W)
    ) u_lfo (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .accept (in_valid),
        .rate   (rate),
        .shape  (shape_e'(shape)),
        .lfo    (lfo)
    );

    // Bypass is unity gain, which makes the multiply exact and keeps latency fixed.
    assign depth_lfo   = depth * lfo;
    assign gain_target = en ? (UNITY - {1'b0, depth_lfo[2*GAIN_W-1:GAIN_W]}) : UNITY;

`ifdef TREMOLO_SMOOTH_EN
    localparam logic [GAIN_W:0] STEP = (GAIN_W+1)'(slew_step(GAIN_W));

    logic [GAIN_W:0] gain_s;
    logic [GAIN_W:0] gain_slewed;

    always_comb begin
        gain_slewed = gain_target;
        if (gain_target > gain_s + STEP) begin
            gain_slewed = gain_s + STEP;
        end else if (gain_target + STEP < gain_s) begin
            gain_slewed = gain_s - STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gain_s <= UNITY;
        end else if (!en) begin
            gain_s <= UNITY;
        end else if (in_valid) begin
            gain_s <= gain_slewed;
        end
    end

    assign gain_use = en ? gain_slewed : UNITY;
`else
    assign gain_use = gain_target;
`endif

    // Stage 1: capture sample and gain on accept; valid tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= UNITY;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sample <= audio_in;
                s1_gain   <= gain_use;
            end
        end
    end

    assign prod_a = {{(GAIN_W+2){s1_sample[DATA_W-1]}}, s1_sample};
    assign prod_b = {{(DATA_W+1){1'b0}}, s1_gain};
    assign prod   = prod_a * prod_b;

    // Taking bits above GAIN_W is the arithmetic shift right plus truncation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            audio_out <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                audio_out <= prod[GAIN_W +: DATA_W];
            end
        end
    end

    // Discarded product bits, gathered so they read as intentionally unused.
    logic unused_bits;
    assign unused_bits = &{1'b0, depth_lfo[GAIN_W-1:0], prod[GAIN_W-1:0],
                           prod[PROD_W-1:GAIN_W+DATA_W]};

endmodule
